cv32e40x_bch_resolve: RTL and testbench

Branch resolution unit that closes the loop on the static branch prediction made in ID. It sits at the ID/EX boundary: it accepts one predicted conditional branch from ID, waits for the EX comparator's actual outcome, and detects a misprediction. On a misprediction it issues a held redirect (correct PC) to IF over a valid/ready handshake. It also keeps a saturating misprediction counter for performance monitoring.

---
 rtl/cv32e40x_pkg.sv | 26 ++
 rtl/cv32e40x_bch_resolve_if.sv | 36 +++
 rtl/cv32e40x_sat_counter.sv | 41 ++++
 rtl/cv32e40x_bch_resolve.sv | 142 ++++++++++++++
 tb/tb_cv32e40x_bch_resolve.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cv32e40x_pkg.sv
// ---------------------------------------------------------------------------
// cv32e40x_pkg
// Shared types and constants for the branch resolution unit and its users.
//   bch_res_state_e  : states of the branch resolution FSM
//   INSTR_LEN_C/W    : fall-through increments for 16-bit / 32-bit branches
//   fall_through_pc  : address of the instruction following a branch
// ---------------------------------------------------------------------------
package cv32e40x_pkg;

    typedef enum logic [1:0] {
        BR_IDLE     = 2'd0,
        BR_WAIT_CMP = 2'd1,
        BR_REDIRECT = 2'd2
    } bch_res_state_e;

    localparam logic [31:0] INSTR_LEN_C = 32'd2;
    localparam logic [31:0] INSTR_LEN_W = 32'd4;

    // Wraps modulo 2^32 so a branch at the top of the address space
    // falls through to address 0.
    function automatic logic [31:0] fall_through_pc(input logic [31:0] pc,
                                                    input logic        compressed);
        return pc + (compressed ? INSTR_LEN_C : INSTR_LEN_W);
    endfunction

endpackage

// File: rtl/cv32e40x_bch_resolve_if.sv
// ---------------------------------------------------------------------------
// cv32e40x_bch_resolve_if
// Groups the two handshakes of the branch resolution unit:
//   ID side : id_valid_i/id_ready_o plus the branch descriptor
//             (id_pc_i, id_bch_target_i, id_prediction_i, id_compressed_i)
//   IF side : redirect_valid_o/redirect_ready_i plus redirect_pc_o
// Modports:
//   master : the environment (ID stage and IF stage)
//   slave  : the branch resolution unit
// ---------------------------------------------------------------------------
interface cv32e40x_bch_resolve_if;

    logic        id_valid_i;
    logic        id_ready_o;
    logic [31:0] id_pc_i;
    logic [31:0] id_bch_target_i;
    logic        id_prediction_i;
    logic        id_compressed_i;

    logic        redirect_valid_o;
    logic        redirect_ready_i;
    logic [31:0] redirect_pc_o;

    modport master (
        output id_valid_i, id_pc_i, id_bch_target_i, id_prediction_i,
               id_compressed_i, redirect_ready_i,
        input  id_ready_o, redirect_valid_o, redirect_pc_o
    );

    modport slave (
        input  id_valid_i, id_pc_i, id_bch_target_i, id_prediction_i,
               id_compressed_i, redirect_ready_i,
        output id_ready_o, redirect_valid_o, redirect_pc_o
    );

endinterface

// File: rtl/cv32e40x_sat_counter.sv
// ---------------------------------------------------------------------------
// cv32e40x_sat_counter
// Generic saturating performance counter.
//   clk, rst_n : clock and synchronous active-low reset
//   clear_i    : synchronous clear, wins over inc_i
//   inc_i      : increment enable; the count sticks at 2^W-1
//   cnt_o      : current count
// ---------------------------------------------------------------------------
module cv32e40x_sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/cv32e40x_bch_resolve.sv
// ---------------------------------------------------------------------------
// cv32e40x_bch_resolve
// Resolves one statically predicted conditional branch at a time. A branch
// is accepted from ID, held until the EX comparator reports the real
// outcome, and on a misprediction a corrected fetch PC is offered to IF
// and held until IF takes it. Mispredictions are counted for performance
// monitoring.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   bus (slave)           : ID accept handshake and IF redirect handshake
//   ex_cmp_valid_i/taken_i: comparator outcome from EX
//   kill_i                : controller flush, drops any branch/redirect
//   resolve_valid_o       : one-cycle pulse per resolved branch
//   resolve_mispredict_o  : qualifies resolve_valid_o
//   mispredict_cnt_o      : saturating misprediction count
//   cnt_clear_i           : clears the counter
// ---------------------------------------------------------------------------
module cv32e40x_bch_resolve
    import cv32e40x_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cv32e40x_bch_resolve_if.slave bus,
    input  logic                  ex_cmp_valid_i,
    input  logic                  ex_cmp_taken_i,
    input  logic                  kill_i,
    output logic                  resolve_valid_o,
    output logic                  resolve_mispredict_o,
    output logic [CNT_W-1:0]      mispredict_cnt_o,
    input  logic                  cnt_clear_i
);

    bch_res_state_e state_q, state_d;

    logic [31:0] pc_q, pc_d;
    logic [31:0] target_q, target_d;
    logic        prediction_q, prediction_d;
    logic        compressed_q, compressed_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic        resolve_valid_q, resolve_valid_d;
    logic        resolve_mispredict_q, resolve_mispredict_d;

    logic        id_ready;
    logic        mispredict;
    logic        cnt_inc;

    always_comb begin
        state_d              = state_q;
        pc_d                 = pc_q;
        target_d             = target_q;
        prediction_d         = prediction_q;
        compressed_d         = compressed_q;
        redirect_pc_d        = redirect_pc_q;
        resolve_valid_d      = 1'b0;
        resolve_mispredict_d = 1'b0;
        id_ready             = 1'b0;
        cnt_inc              = 1'b0;
        mispredict           = ex_cmp_taken_i != prediction_q;

        case (state_q)
            BR_IDLE: begin
                id_ready = !kill_i;
                if (bus.id_valid_i && id_ready) begin
                    pc_d         = bus.id_pc_i;
                    target_d     = bus.id_bch_target_i;
                    prediction_d = bus.id_prediction_i;
                    compressed_d = bus.id_compressed_i;
                    state_d      = BR_WAIT_CMP;
                end
            end

            // A kill in the same cycle as the comparator result discards
            // the outcome entirely: no pulse, no count, no PC update.
            BR_WAIT_CMP: begin
                if (kill_i) begin
                    state_d = BR_IDLE;
                end else if (ex_cmp_valid_i) begin
                    redirect_pc_d        = ex_cmp_taken_i ? target_q
                                                          : fall_through_pc(pc_q, compressed_q);
                    resolve_valid_d      = 1'b1;
                    resolve_mispredict_d = mispredict;
                    cnt_inc              = mispredict;
                    state_d              = mispredict ? BR_REDIRECT : BR_IDLE;
                end
            end

            BR_REDIRECT: begin
                if (kill_i || bus.redirect_ready_i) begin
                    state_d = BR_IDLE;
                end
            end

            default: begin
                state_d = BR_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q              <= BR_IDLE;
            pc_q                 <= '0;
            target_q             <= '0;
            prediction_q         <= 1'b0;
            compressed_q         <= 1'b0;
            redirect_pc_q        <= '0;
            resolve_valid_q      <= 1'b0;
            resolve_mispredict_q <= 1'b0;
        end else begin
            state_q              <= state_d;
            pc_q                 <= pc_d;
            target_q             <= target_d;
            prediction_q         <= prediction_d;
            compressed_q         <= compressed_d;
            redirect_pc_q        <= redirect_pc_d;
            resolve_valid_q      <= resolve_valid_d;
            resolve_mispredict_q <= resolve_mispredict_d;
        end
    end

    cv32e40x_sat_counter #(
        .W (CNT_W)
    ) u_mispredict_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (cnt_clear_i),
        .inc_i   (cnt_inc),
        .cnt_o   (mispredict_cnt_o)
    );

    // The redirect is driven purely from the registered state, so it
    // stays stable for the whole handshake and only drops on the edge
    // after ready, kill or reset.
    assign bus.id_ready_o        = id_ready;
    assign bus.redirect_valid_o  = (state_q == BR_REDIRECT);
    assign bus.redirect_pc_o     = redirect_pc_q;
    assign resolve_valid_o       = resolve_valid_q;
    assign resolve_mispredict_o  = resolve_mispredict_q;

endmodule

// File: tb/tb_cv32e40x_bch_resolve.sv
// ---------------------------------------------------------------------------
// tb_cv32e40x_bch_resolve
// Drives two copies of the unit (16-bit and 2-bit counters) with identical
// stimulus and compares both against a transaction-level model of a
// single outstanding branch and a single outstanding redirect.
// ---------------------------------------------------------------------------
module tb_cv32e40x_bch_resolve;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cv32e40x_bch_resolve_if bus_a ();
    cv32e40x_bch_resolve_if bus_b ();

    logic        ex_cmp_valid, ex_cmp_taken, kill, cnt_clear;
    logic        rv_a, rm_a, rv_b, rm_b;
    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;

    // second copy mirrors the stimulus of the first
    assign bus_b.id_valid_i       = bus_a.id_valid_i;
    assign bus_b.id_pc_i          = bus_a.id_pc_i;
    assign bus_b.id_bch_target_i  = bus_a.id_bch_target_i;
    assign bus_b.id_prediction_i  = bus_a.id_prediction_i;
    assign bus_b.id_compressed_i  = bus_a.id_compressed_i;
    assign bus_b.redirect_ready_i = bus_a.redirect_ready_i;

    cv32e40x_bch_resolve #(.CNT_W(16)) dut_a (
        .clk                  (clk),
        .rst_n                (rst_n),
        .bus                  (bus_a),
        .ex_cmp_valid_i       (ex_cmp_valid),
        .ex_cmp_taken_i       (ex_cmp_taken),
        .kill_i               (kill),
        .resolve_valid_o      (rv_a),
        .resolve_mispredict_o (rm_a),
        .mispredict_cnt_o     (cnt_a),
        .cnt_clear_i          (cnt_clear)
    );

    cv32e40x_bch_resolve #(.CNT_W(2)) dut_b (
        .clk                  (clk),
        .rst_n                (rst_n),
        .bus                  (bus_b),
        .ex_cmp_valid_i       (ex_cmp_valid),
        .ex_cmp_taken_i       (ex_cmp_taken),
        .kill_i               (kill),
        .resolve_valid_o      (rv_b),
        .resolve_mispredict_o (rm_b),
        .mispredict_cnt_o     (cnt_b),
        .cnt_clear_i          (cnt_clear)
    );

    int checks = 0;
    int errors = 0;

    // reference model: one held branch, one outstanding redirect, counts
    bit          m_busy, m_pend, m_pred, m_comp, m_rv, m_rm;
    logic [31:0] m_pc, m_tgt, m_rpc;
    int unsigned m_cnt_a, m_cnt_b;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_dut(input string tag, input logic rv, input logic rm,
                             input logic [31:0] rpc, input logic rdv,
                             input logic [31:0] cnt, input int unsigned m_cnt);
        check({tag, "_resolve_valid"},  {31'b0, rv},  {31'b0, m_rv});
        check({tag, "_resolve_mis"},    {31'b0, rm},  {31'b0, m_rm});
        check({tag, "_redirect_valid"}, {31'b0, rdv}, {31'b0, m_pend});
        check({tag, "_redirect_pc"},    rpc,          m_rpc);
        check({tag, "_count"},          cnt,          m_cnt);
    endtask

    // one clock: check ready, advance the model, clock, check outputs
    task automatic cycle();
        bit inc;
        #1;
        if (rst_n) begin
            check("a_id_ready", {31'b0, bus_a.id_ready_o}, {31'b0, !m_busy && !m_pend && !kill});
            check("b_id_ready", {31'b0, bus_b.id_ready_o}, {31'b0, !m_busy && !m_pend && !kill});
        end
        inc  = 1'b0;
        m_rv = 1'b0;
        m_rm = 1'b0;
        if (!rst_n) begin
            m_busy = 0; m_pend = 0; m_rpc = 0; m_cnt_a = 0; m_cnt_b = 0;
        end else begin
            if (kill) begin
                m_busy = 0;
                m_pend = 0;
            end else if (m_pend) begin
                if (bus_a.redirect_ready_i) m_pend = 0;
            end else if (m_busy) begin
                if (ex_cmp_valid) begin
                    m_rpc  = ex_cmp_taken ? m_tgt : m_pc + (m_comp ? 32'd2 : 32'd4);
                    m_rv   = 1;
                    m_rm   = (ex_cmp_taken != m_pred);
                    m_pend = m_rm;
                    m_busy = 0;
                    inc    = m_rm;
                end
            end else if (bus_a.id_valid_i) begin
                m_pc   = bus_a.id_pc_i;
                m_tgt  = bus_a.id_bch_target_i;
                m_pred = bus_a.id_prediction_i;
                m_comp = bus_a.id_compressed_i;
                m_busy = 1;
            end
            if (cnt_clear) begin
                m_cnt_a = 0;
                m_cnt_b = 0;
            end else if (inc) begin
                if (m_cnt_a < 65535) m_cnt_a++;
                if (m_cnt_b < 3)     m_cnt_b++;
            end
        end
        @(posedge clk);
        #1;
        check_dut("a", rv_a, rm_a, bus_a.redirect_pc_o, bus_a.redirect_valid_o, {16'b0, cnt_a}, m_cnt_a);
        check_dut("b", rv_b, rm_b, bus_b.redirect_pc_o, bus_b.redirect_valid_o, {30'b0, cnt_b}, m_cnt_b);
    endtask

    task automatic set_idle();
        bus_a.id_valid_i       = 0;
        bus_a.id_pc_i          = '0;
        bus_a.id_bch_target_i  = '0;
        bus_a.id_prediction_i  = 0;
        bus_a.id_compressed_i  = 0;
        bus_a.redirect_ready_i = 0;
        ex_cmp_valid = 0; ex_cmp_taken = 0; kill = 0; cnt_clear = 0;
    endtask

    task automatic offer(input logic [31:0] pc, input logic [31:0] tgt,
                         input logic pred, input logic comp);
        bus_a.id_valid_i      = 1;
        bus_a.id_pc_i         = pc;
        bus_a.id_bch_target_i = tgt;
        bus_a.id_prediction_i = pred;
        bus_a.id_compressed_i = comp;
        cycle();
        bus_a.id_valid_i = 0;
    endtask

    task automatic resolve(input logic taken);
        ex_cmp_valid = 1;
        ex_cmp_taken = taken;
        cycle();
        ex_cmp_valid = 0;
    endtask

    task automatic take_redirect();
        bus_a.redirect_ready_i = 1;
        cycle();
        bus_a.redirect_ready_i = 0;
    endtask

    initial begin
        rst_n = 0;
        set_idle();
        cycle();
        cycle();
        rst_n = 1;
        cycle();

        // correct prediction
        offer(32'h100, 32'h80, 1, 0);
        resolve(1);
        check("plan_ok_pulse", {30'b0, rv_a, rm_a}, 32'h2);
        cycle();

        // mispredict not-taken, redirect held for three cycles
        offer(32'h200, 32'h100, 1, 0);
        resolve(0);
        check("plan_rpc_204", bus_a.redirect_pc_o, 32'h204);
        check("plan_cnt_1", {16'b0, cnt_a}, 32'd1);
        repeat (3) cycle();
        check("plan_rpc_held", bus_a.redirect_pc_o, 32'h204);
        take_redirect();

        // mispredict taken / not-taken with compressed branch
        offer(32'h300, 32'h340, 0, 1);
        resolve(1);
        check("plan_rpc_340", bus_a.redirect_pc_o, 32'h340);
        take_redirect();
        offer(32'h300, 32'h340, 1, 1);
        resolve(0);
        check("plan_rpc_302", bus_a.redirect_pc_o, 32'h302);
        take_redirect();

        // fall-through wraps
        offer(32'hFFFF_FFFC, 32'h40, 1, 0);
        resolve(0);
        check("plan_rpc_wrap", bus_a.redirect_pc_o, 32'h0);
        take_redirect();

        // kill with comparator result
        offer(32'h400, 32'h500, 1, 0);
        kill = 1;
        resolve(0);
        kill = 0;
        check("plan_kill_cmp", {31'b0, rv_a}, 32'd0);
        cycle();

        // kill during redirect
        offer(32'h600, 32'h700, 0, 0);
        resolve(1);
        cycle();
        kill = 1;
        cycle();
        kill = 0;
        check("plan_kill_redir", {31'b0, bus_a.redirect_valid_o}, 32'd0);

        // kill with id_valid in idle, then a stray comparator result
        kill = 1;
        bus_a.id_valid_i = 1;
        bus_a.id_pc_i = 32'h800;
        cycle();
        kill = 0;
        bus_a.id_valid_i = 0;
        resolve(0);

        // saturation of the narrow counter
        for (int i = 0; i < 5; i++) begin
            offer(32'h1000 + 32'(i) * 8, 32'h2000, 0, 0);
            resolve(1);
            take_redirect();
        end
        check("plan_sat_3", {30'b0, cnt_b}, 32'd3);

        // clear coincident with a mispredict
        offer(32'h900, 32'h980, 1, 0);
        cnt_clear = 1;
        resolve(0);
        cnt_clear = 0;
        check("plan_clear", {16'b0, cnt_a}, 32'd0);
        take_redirect();

        // reset while waiting for the comparator
        offer(32'hA00, 32'hB00, 1, 0);
        rst_n = 0;
        cycle();
        rst_n = 1;
        check("plan_rst_redir", {31'b0, bus_a.redirect_valid_o}, 32'd0);
        cycle();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            bus_a.id_valid_i       = ($urandom_range(0, 1) == 1);
            bus_a.id_pc_i          = $urandom;
            bus_a.id_bch_target_i  = $urandom;
            bus_a.id_prediction_i  = ($urandom_range(0, 1) == 1);
            bus_a.id_compressed_i  = ($urandom_range(0, 1) == 1);
            bus_a.redirect_ready_i = ($urandom_range(0, 2) == 0);
            ex_cmp_valid           = ($urandom_range(0, 2) != 0);
            ex_cmp_taken           = ($urandom_range(0, 1) == 1);
            kill                   = ($urandom_range(0, 19) == 0);
            cnt_clear              = ($urandom_range(0, 39) == 0);
            rst_n                  = ($urandom_range(0, 99) != 0);
            cycle();
        end
        rst_n = 1;
        set_idle();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
